// File: rtl/ml_demod_pkg.sv
// ml_demod_pkg
//  Shared types and constants for the ml_demodulator scheduler slice.
//  - state_e       : scheduler FSM states
//  - COMPUTE_CYC   : cycles from trigger to cal_done inside the demodulator
//  - BUF_VEC       : demodulator output buffer capacity in vectors
//  - BITS_PER_VEC  : bits read out of the buffer per vector
//  - Y_W / R_W     : widths of the y_hat vector and R matrix buses
package ml_demod_pkg;

  localparam int COMPUTE_CYC  = 64;
  localparam int BUF_VEC      = 32;
  localparam int BITS_PER_VEC = 8;
  localparam int Y_W          = 160;
  localparam int R_W          = 320;

  localparam int OUT_W  = 6;  // holds 0..BUF_VEC
  localparam int BIT_W  = 3;  // counts BITS_PER_VEC read handshakes
  localparam int WAIT_W = 7;

  localparam logic [OUT_W-1:0]  BUF_VEC_V = OUT_W'(BUF_VEC);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_VEC - 1);
  // COMPUTE counts WAIT_LOAD down to 0 inclusive, so it lasts COMPUTE_CYC cycles
  // and the trigger-to-trigger spacing is COMPUTE_CYC + 2 (TRIG + LOAD).
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(COMPUTE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    TRIG    = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4
  } state_e;

endpackage

// File: rtl/ml_demod_credit_cnt.sv
// ml_demod_credit_cnt
//  Tracks how many triggered vectors are still unread in the demodulator's
//  output buffer. Every read handshake advances a bit counter; each wrap of
//  that counter retires one vector.
//  Ports:
//   i_clk, i_reset_n     clock, asynchronous active-low reset
//   i_inc                one vector triggered this cycle
//   i_rd_hs              one buffer bit read this cycle (vld && rdy)
//   o_outstanding        vectors triggered but not fully read
//   o_bit_cnt            bits read out of the current vector
//   o_err_underflow      sticky: a retire was seen with nothing outstanding
module ml_demod_credit_cnt
  import ml_demod_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_inc,
  input  logic             i_rd_hs,
  output logic [OUT_W-1:0] o_outstanding,
  output logic [BIT_W-1:0] o_bit_cnt,
  output logic             o_err_underflow
);

  logic [BIT_W-1:0] r_bit_cnt;
  logic [OUT_W-1:0] r_outstanding;
  logic             r_err_underflow;
  logic             w_wrap;

  assign w_wrap = i_rd_hs && (r_bit_cnt == BIT_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bit_cnt       <= '0;
      r_outstanding   <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      if (i_rd_hs) r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      // A trigger and a retire in the same cycle cancel out.
      case ({i_inc, w_wrap})
        2'b10: begin
          if (r_outstanding != BUF_VEC_V) r_outstanding <= r_outstanding + OUT_W'(1);
        end
        2'b01: begin
          if (r_outstanding != '0) r_outstanding <= r_outstanding - OUT_W'(1);
          else                     r_err_underflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_outstanding   = r_outstanding;
  assign o_bit_cnt       = r_bit_cnt;
  assign o_err_underflow = r_err_underflow;

endmodule

// File: rtl/ml_demod_scheduler.sv
// ml_demod_scheduler
//  Sequences ml_demodulator over a frame of symbol vectors. Takes (y_hat, R)
//  pairs from upstream, issues one-cycle triggers spaced by the search time,
//  never triggers more vectors than the output buffer can hold unread, and
//  pulses o_frame_done once every bit of the frame has been drained.
//  Handshakes: a transfer happens on a rising clock edge where valid and
//  ready are both high; valid may not depend on ready, ready (o_in_rdy) is
//  only high in LOAD with buffer room, and i_rd_vld/i_rd_rdy are observed
//  taps where each cycle with both high drains one bit.
//  Ports:
//   i_clk, i_reset_n           clock, asynchronous active-low reset
//   i_start, i_frame_len       frame start pulse and length (sampled in IDLE)
//   i_in_vld, o_in_rdy         upstream handshake
//   i_y_hat, i_r               upstream vector / matrix
//   o_trig, o_y_hat, o_r       to demodulator; data held stable between loads
//   i_rd_vld, i_rd_rdy         demodulator read-side handshake taps
//   o_busy                     state != IDLE
//   o_frame_done               one-cycle frame completion pulse
//   o_outstanding              vectors triggered but not fully read
//   o_dbg_state                current FSM state
//   o_dbg_err_underflow        sticky retire-with-nothing-outstanding flag
module ml_demod_scheduler
  import ml_demod_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_frame_len,
  input  logic             i_in_vld,
  output logic             o_in_rdy,
  input  logic [Y_W-1:0]   i_y_hat,
  input  logic [R_W-1:0]   i_r,
  output logic             o_trig,
  output logic [Y_W-1:0]   o_y_hat,
  output logic [R_W-1:0]   o_r,
  input  logic             i_rd_vld,
  input  logic             i_rd_rdy,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic [OUT_W-1:0] o_outstanding,
  output logic [2:0]       o_dbg_state,
  output logic             o_dbg_err_underflow
);

  state_e              r_state;
  logic [LEN_W-1:0]    r_remaining;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [Y_W-1:0]      r_y_hat;
  logic [R_W-1:0]      r_r;
  logic                r_trig;
  logic                r_frame_done;

  logic                w_in_rdy;
  logic                w_xfer;
  logic                w_rd_hs;
  logic [OUT_W-1:0]    w_outstanding;
  logic [BIT_W-1:0]    w_bit_cnt;
  logic                w_err_underflow;

  // Ready only while loading and while the buffer has room for one more vector.
  assign w_in_rdy = (r_state == LOAD) && (w_outstanding < BUF_VEC_V);
  assign w_xfer   = i_in_vld && w_in_rdy;
  assign w_rd_hs  = i_rd_vld && i_rd_rdy;

  ml_demod_credit_cnt u_credit (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_inc           (r_state == TRIG),
    .i_rd_hs         (w_rd_hs),
    .o_outstanding   (w_outstanding),
    .o_bit_cnt       (w_bit_cnt),
    .o_err_underflow (w_err_underflow)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_remaining  <= '0;
      r_wait_cnt   <= '0;
      r_y_hat      <= '0;
      r_r          <= '0;
      r_trig       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_trig       <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (i_frame_len != '0) begin
              r_remaining <= i_frame_len;
              r_state     <= LOAD;
            end else begin
              r_frame_done <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (w_xfer) begin
            r_y_hat <= i_y_hat;
            r_r     <= i_r;
            r_trig  <= 1'b1;  // high for exactly the TRIG cycle
            r_state <= TRIG;
          end
        end
        TRIG: begin
          r_remaining <= r_remaining - LEN_W'(1);
          r_wait_cnt  <= WAIT_LOAD;
          r_state     <= COMPUTE;
        end
        COMPUTE: begin
          if (r_wait_cnt == '0) begin
            r_state <= (r_remaining != '0) ? LOAD : DRAIN;
          end else begin
            r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
          end
        end
        DRAIN: begin
          if ((w_outstanding == '0) && (w_bit_cnt == '0)) begin
            r_frame_done <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_in_rdy            = w_in_rdy;
  assign o_trig              = r_trig;
  assign o_y_hat             = r_y_hat;
  assign o_r                 = r_r;
  assign o_busy              = (r_state != IDLE);
  assign o_frame_done        = r_frame_done;
  assign o_outstanding       = w_outstanding;
  assign o_dbg_state         = r_state;
  assign o_dbg_err_underflow = w_err_underflow;

endmodule

// File: tb/tb_ml_demod_scheduler.sv
module tb_ml_demod_scheduler;
  import ml_demod_pkg::*;

  // ---------------- clock / reset ----------------
  logic           i_clk = 1'b0;
  logic           i_reset_n;
  logic           i_start;
  logic [15:0]    i_frame_len;
  logic           i_in_vld;
  logic           o_in_rdy;
  logic [Y_W-1:0] i_y_hat;
  logic [R_W-1:0] i_r;
  logic           o_trig;
  logic [Y_W-1:0] o_y_hat;
  logic [R_W-1:0] o_r;
  logic           i_rd_vld;
  logic           i_rd_rdy;
  logic           o_busy;
  logic           o_frame_done;
  logic [5:0]     o_outstanding;
  logic [2:0]     o_dbg_state;
  logic           o_dbg_err_underflow;

  always #5 i_clk = ~i_clk;

  ml_demod_scheduler #(.LEN_W(16)) dut (
    .i_clk               (i_clk),
    .i_reset_n           (i_reset_n),
    .i_start             (i_start),
    .i_frame_len         (i_frame_len),
    .i_in_vld            (i_in_vld),
    .o_in_rdy            (o_in_rdy),
    .i_y_hat             (i_y_hat),
    .i_r                 (i_r),
    .o_trig              (o_trig),
    .o_y_hat             (o_y_hat),
    .o_r                 (o_r),
    .i_rd_vld            (i_rd_vld),
    .i_rd_rdy            (i_rd_rdy),
    .o_busy              (o_busy),
    .o_frame_done        (o_frame_done),
    .o_outstanding       (o_outstanding),
    .o_dbg_state         (o_dbg_state),
    .o_dbg_err_underflow (o_dbg_err_underflow)
  );

  // ---------------- scoreboard state ----------------
  localparam int DW = Y_W + R_W;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] held;
  bit            hold_ok;
  bit            rd_auto;
  bit            gap_mode;
  int            n_vec = 0;
  int            n_err = 0;
  int            cycle_cnt = 0;
  int            trig_cnt, trig_done, rd_done;
  int            last_trig_cyc, rd8_cyc, start_cyc;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [Y_W-1:0] rand_y();
    logic [Y_W-1:0] v;
    for (int i = 0; i < Y_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [R_W-1:0] rand_r();
    logic [R_W-1:0] v;
    for (int i = 0; i < R_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic clr_model();
    exp_q.delete();
    trig_cnt = 0; trig_done = 0; rd_done = 0;
    last_trig_cyc = 0; rd8_cyc = 0; hold_ok = 1'b1;
  endtask

  task automatic rd_on();
    rd_auto = 1'b1; i_rd_vld = (rd_done < 8 * trig_done); i_rd_rdy = 1'b1;
  endtask

  task automatic rd_off();
    rd_auto = 1'b0; i_rd_vld = 1'b0; i_rd_rdy = 1'b0;
  endtask

  // ---------------- driver / monitor: advance one cycle ----------------
  // Captures the handshakes that the coming posedge will complete, then
  // samples outputs at the following negedge.
  task automatic cyc();
    bit            rd_hs, xfer, tr;
    logic [DW-1:0] e;
    rd_hs = i_rd_vld && i_rd_rdy;
    xfer  = i_in_vld && o_in_rdy;
    tr    = o_trig;
    if (xfer) exp_q.push_back({i_y_hat, i_r});
    @(negedge i_clk);
    cycle_cnt++;
    if (rd_hs) begin
      rd_done++;
      if (rd_done == 8) rd8_cyc = cycle_cnt;
    end
    if (tr) trig_done++;
    if (xfer) begin
      i_y_hat = rand_y();
      i_r     = rand_r();
    end
    if (o_trig) begin
      trig_cnt++;
      if (exp_q.size() == 0) check("trig_without_load", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("trig_data", {o_y_hat, o_r}, e);
      end
      if (gap_mode && trig_cnt > 1) begin
        check("trig_gap", cycle_cnt - last_trig_cyc, 66);
        check("data_hold", hold_ok, 1);
      end
      last_trig_cyc = cycle_cnt;
      held = {o_y_hat, o_r};
      hold_ok = 1'b1;
    end else if ({o_y_hat, o_r} !== held) begin
      hold_ok = 1'b0;
    end
    if (rd_auto) begin
      i_rd_vld = (rd_done < 8 * trig_done);
      i_rd_rdy = 1'b1;
    end
  endtask

  task automatic wait_trig(input int n, input int budget);
    int k = 0;
    while (trig_cnt < n && k < budget) begin
      cyc();
      k++;
    end
    check("wait_trig", trig_cnt >= n, 1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    bit seen = 1'b0;
    while (!seen && k < budget) begin
      cyc();
      k++;
      if (o_frame_done) seen = 1'b1;
    end
    check("frame_done_seen", seen, 1);
  endtask

  task automatic start_frame(input logic [15:0] len);
    i_frame_len = len;
    i_start = 1'b1;
    start_cyc = cycle_cnt;
    cyc();
    i_start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    i_reset_n = 1'b1; i_start = 1'b0; i_frame_len = '0; i_in_vld = 1'b0;
    i_y_hat = rand_y(); i_r = rand_r(); held = '0;
    rd_auto = 1'b0; gap_mode = 1'b0; i_rd_vld = 1'b0; i_rd_rdy = 1'b0;
    clr_model();
    #1 i_reset_n = 1'b0;
    @(negedge i_clk);
    check("rst_trig", o_trig, 0);
    check("rst_in_rdy", o_in_rdy, 0);
    check("rst_busy", o_busy, 0);
    check("rst_frame_done", o_frame_done, 0);
    check("rst_outstanding", o_outstanding, 0);
    check("rst_y_hat", o_y_hat, 0);
    check("rst_r", o_r, 0);
    check("rst_state", o_dbg_state, 0);
    check("rst_underflow", o_dbg_err_underflow, 0);
    i_reset_n = 1'b1;
    cyc();

    // 1: single vector
    clr_model(); i_in_vld = 1'b1;
    start_frame(16'd1);
    check("t1_state_load", o_dbg_state, 1);
    cyc();
    check("t1_trig", o_trig, 1);
    check("t1_trig_latency", last_trig_cyc - start_cyc, 2);
    repeat (70) cyc();
    check("t1_trig_count", trig_cnt, 1);
    check("t1_outstanding", o_outstanding, 1);
    check("t1_state_drain", o_dbg_state, 4);
    rd_on();
    k = 0;
    while (rd_done < 8 && k < 20) begin cyc(); k++; end
    check("t1_reads", rd_done, 8);
    check("t1_out_zero", o_outstanding, 0);
    check("t1_done_not_yet", o_frame_done, 0);
    cyc();
    check("t1_done", o_frame_done, 1);
    cyc();
    check("t1_done_pulse", o_frame_done, 0);
    check("t1_idle", o_busy, 0);
    check("t1_sb_empty", exp_q.size(), 0);
    rd_off();

    // 2: trigger spacing and data hold
    clr_model(); gap_mode = 1'b1; rd_on(); i_in_vld = 1'b1;
    start_frame(16'd4);
    wait_done(450);
    gap_mode = 1'b0;
    check("t2_trig_count", trig_cnt, 4);
    check("t2_reads", rd_done, 32);
    check("t2_out_zero", o_outstanding, 0);
    rd_off();

    // 3: buffer backpressure
    clr_model(); i_in_vld = 1'b1;
    start_frame(16'd40);
    wait_trig(32, 2300);
    repeat (100) cyc();
    check("t3_trig_count", trig_cnt, 32);
    check("t3_in_rdy_low", o_in_rdy, 0);
    check("t3_outstanding_full", o_outstanding, 32);
    check("t3_state_load", o_dbg_state, 1);
    rd_on();
    wait_trig(33, 50);
    check("t3_trig33_after_read8", last_trig_cyc - rd8_cyc, 1);
    wait_done(1000);
    check("t3_trig_total", trig_cnt, 40);
    check("t3_reads", rd_done, 320);
    check("t3_underflow", o_dbg_err_underflow, 0);
    rd_off();

    // 4: bit_cnt wrap coincides with TRIG
    clr_model(); i_in_vld = 1'b1;
    start_frame(16'd2);
    wait_trig(1, 10);
    repeat (3) cyc();
    i_rd_vld = 1'b1; i_rd_rdy = 1'b1;
    repeat (7) cyc();
    i_rd_vld = 1'b0; i_rd_rdy = 1'b0;
    cyc();
    check("t4_out_before", o_outstanding, 1);
    k = 0;
    while (!o_trig && k < 100) begin cyc(); k++; end
    check("t4_trig2", o_trig, 1);
    i_rd_vld = 1'b1; i_rd_rdy = 1'b1;
    cyc();
    i_rd_vld = 1'b0; i_rd_rdy = 1'b0;
    check("t4_coincide_out", o_outstanding, 1);
    check("t4_coincide_underflow", o_dbg_err_underflow, 0);
    check("t4_reads", rd_done, 8);
    rd_on();
    wait_done(200);
    check("t4_reads_total", rd_done, 16);
    rd_off();

    // 5: zero-length frame, start ignored while busy
    clr_model(); i_in_vld = 1'b0;
    start_frame(16'd0);
    check("t5_done", o_frame_done, 1);
    check("t5_no_trig", o_trig, 0);
    check("t5_idle", o_busy, 0);
    cyc();
    check("t5_done_pulse", o_frame_done, 0);
    check("t5_trig_count", trig_cnt, 0);
    i_in_vld = 1'b1;
    start_frame(16'd1);
    wait_trig(1, 10);
    repeat (5) cyc();
    check("t5_state_compute", o_dbg_state, 3);
    start_frame(16'd5);
    check("t5_start_ignored", o_dbg_state, 3);
    rd_on();
    wait_done(200);
    check("t5_single_trig", trig_cnt, 1);
    check("t5_reads", rd_done, 8);
    rd_off();

    // 6: reset during COMPUTE of vector 3 of 10
    clr_model(); i_in_vld = 1'b1;
    start_frame(16'd10);
    wait_trig(3, 300);
    repeat (10) cyc();
    check("t6_state_compute", o_dbg_state, 3);
    check("t6_out_before", o_outstanding, 3);
    i_in_vld = 1'b0;
    i_reset_n = 1'b0;
    #1;
    check("t6_rst_trig", o_trig, 0);
    check("t6_rst_in_rdy", o_in_rdy, 0);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_frame_done", o_frame_done, 0);
    check("t6_rst_outstanding", o_outstanding, 0);
    check("t6_rst_y_hat", o_y_hat, 0);
    check("t6_rst_r", o_r, 0);
    check("t6_rst_state", o_dbg_state, 0);
    repeat (3) cyc();
    clr_model();
    i_reset_n = 1'b1;
    cyc();
    i_in_vld = 1'b1; rd_on();
    start_frame(16'd2);
    wait_done(300);
    check("t6_trig_count", trig_cnt, 2);
    check("t6_reads", rd_done, 16);
    check("t6_sb_empty", exp_q.size(), 0);
    check("t6_underflow", o_dbg_err_underflow, 0);
    rd_off();
    i_in_vld = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
